key_press_decoder: RTL and testbench



---
 rtl/key_pkg.sv | 29 ++
 rtl/key_press_decoder.sv | 137 +++++++++++++
 tb/tb_key_press_decoder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key path: FSM state encoding, key level constants
// and counter sizing helpers used by the gesture decoder.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } key_fsm_e;

  // Debounced key levels as reported by the key filter alongside key_flag.
  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width able to hold max_cnt-1; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    return (max_cnt < 2) ? 1 : $clog2(max_cnt);
  endfunction

endpackage

// File: rtl/key_press_decoder.sv
// Classifies debounced key events into short, double, long and auto-repeat
// gestures, each reported as a registered one-cycle pulse.
module key_press_decoder
  import key_pkg::*;
#(
  parameter int unsigned LONG_CNT   = 50_000_000,
  parameter int unsigned REPEAT_CNT = 10_000_000,
  parameter int unsigned DCLICK_CNT = 15_000_000,
  parameter bit          DCLICK_EN  = 1'b1
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic key_flag,
  input  logic key_state,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic pressed
);

  localparam int unsigned CNT_MAX = max3(LONG_CNT, REPEAT_CNT, DCLICK_CNT);
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CNT - 1);
  localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CNT - 1);

  key_fsm_e         state;
  key_fsm_e         state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  logic evt_press;
  logic evt_release;
  logic short_next;
  logic double_next;
  logic long_next;
  logic repeat_next;
  logic pressed_next;

  assign evt_press   = key_flag && (key_state == KEY_PRESSED);
  assign evt_release = key_flag && (key_state == KEY_RELEASED);

  // A release always wins over a coincident terminal count; a press in the
  // double-click window wins over the window timeout.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    short_next  = 1'b0;
    double_next = 1'b0;
    long_next   = 1'b0;
    repeat_next = 1'b0;

    case (state)
      IDLE: begin
        if (evt_press) begin
          state_next = PRESSED;
        end
      end

      PRESSED: begin
        cnt_next = cnt + CNT_W'(1);
        if (evt_release) begin
          if (DCLICK_EN) begin
            state_next = WAIT_SECOND;
          end else begin
            state_next = IDLE;
            short_next = 1'b1;
          end
        end else if (cnt == LONG_TC) begin
          state_next = LONG_HELD;
          long_next  = 1'b1;
        end
      end

      LONG_HELD: begin
        cnt_next = cnt + CNT_W'(1);
        if (evt_release) begin
          state_next = IDLE;
        end else if (cnt == REPEAT_TC) begin
          repeat_next = 1'b1;
          cnt_next    = '0;
        end
      end

      WAIT_SECOND: begin
        cnt_next = cnt + CNT_W'(1);
        if (evt_press) begin
          state_next = SECOND_PRESSED;
        end else if (cnt == DCLICK_TC) begin
          state_next = IDLE;
          short_next = 1'b1;
        end
      end

      SECOND_PRESSED: begin
        if (evt_release) begin
          state_next  = IDLE;
          double_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (state_next != state) begin
      cnt_next = '0;
    end

    pressed_next = (state_next == PRESSED) || (state_next == LONG_HELD) ||
                   (state_next == SECOND_PRESSED);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      pressed      <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      short_press  <= short_next;
      double_press <= double_next;
      long_press   <= long_next;
      repeat_pulse <= repeat_next;
      pressed      <= pressed_next;
    end
  end

endmodule

// File: tb/tb_key_press_decoder.sv
// Gesture decoder bench: two instances (double-click on/off) share stimulus and
// are checked against a timestamp-based gesture model plus a directed vector table.
module tb_key_press_decoder;

  localparam int LONG   = 100;
  localparam int REP    = 20;
  localparam int DCL    = 30;

  localparam int P_IDLE  = 0;
  localparam int P_HOLD  = 1;
  localparam int P_LONG  = 2;
  localparam int P_WIN   = 3;
  localparam int P_HOLD2 = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic key_flag;
  logic key_state;

  logic en_short, en_double, en_long, en_repeat, en_pressed;
  logic dis_short, dis_double, dis_long, dis_repeat, dis_pressed;
  logic [4:0] out_en;
  logic [4:0] out_dis;

  int checks = 0;
  int errors = 0;

  // Gesture model: phase plus the edge index at which the phase was entered.
  int         edge_k = 0;
  int         ph[2];
  int         t_mark[2];
  logic [4:0] exp_v[2];

  typedef struct {
    int         idle;
    logic       kf;
    logic       ks;
    logic [4:0] exp_en;
    logic [4:0] exp_dis;
  } vec_t;

  vec_t       vecs[21];
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  assign out_en  = {en_short, en_double, en_long, en_repeat, en_pressed};
  assign out_dis = {dis_short, dis_double, dis_long, dis_repeat, dis_pressed};

  key_press_decoder #(
    .LONG_CNT(LONG), .REPEAT_CNT(REP), .DCLICK_CNT(DCL), .DCLICK_EN(1'b1)
  ) u_en (
    .Clk(clk), .Reset_n(reset_n), .key_flag(key_flag), .key_state(key_state),
    .short_press(en_short), .double_press(en_double), .long_press(en_long),
    .repeat_pulse(en_repeat), .pressed(en_pressed)
  );

  key_press_decoder #(
    .LONG_CNT(LONG), .REPEAT_CNT(REP), .DCLICK_CNT(DCL), .DCLICK_EN(1'b0)
  ) u_dis (
    .Clk(clk), .Reset_n(reset_n), .key_flag(key_flag), .key_state(key_state),
    .short_press(dis_short), .double_press(dis_double), .long_press(dis_long),
    .repeat_pulse(dis_repeat), .pressed(dis_pressed)
  );

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i]     = P_IDLE;
      t_mark[i] = 0;
      exp_v[i]  = 5'b0;
    end
  endtask

  // Output vector order: {short, double, long, repeat, pressed}; index 0 has double-click enabled.
  task automatic model_step(input logic pr, input logic rl);
    logic [3:0] pulse;
    edge_k++;
    for (int i = 0; i < 2; i++) begin
      pulse = 4'b0000;
      case (ph[i])
        P_IDLE: if (pr) begin ph[i] = P_HOLD; t_mark[i] = edge_k; end
        P_HOLD: begin
          if (rl) begin
            if (i == 0) begin ph[i] = P_WIN; t_mark[i] = edge_k; end
            else begin ph[i] = P_IDLE; pulse = 4'b1000; end
          end else if (edge_k - t_mark[i] == LONG) begin
            ph[i] = P_LONG; t_mark[i] = edge_k; pulse = 4'b0010;
          end
        end
        P_LONG: begin
          if (rl) ph[i] = P_IDLE;
          else if ((edge_k - t_mark[i]) % REP == 0) pulse = 4'b0001;
        end
        P_WIN: begin
          if (pr) ph[i] = P_HOLD2;
          else if (edge_k - t_mark[i] == DCL) begin ph[i] = P_IDLE; pulse = 4'b1000; end
        end
        P_HOLD2: if (rl) begin ph[i] = P_IDLE; pulse = 4'b0100; end
        default: ph[i] = P_IDLE;
      endcase
      exp_v[i] = {pulse, (ph[i] == P_HOLD) || (ph[i] == P_LONG) || (ph[i] == P_HOLD2)};
    end
  endtask

  task automatic step(input logic kf, input logic ks);
    key_flag  = kf;
    key_state = ks;
    @(posedge clk);
    #1;
    model_step(kf & ~ks, kf & ks);
    check("model_en", {5'b0, out_en}, {5'b0, exp_v[0]});
    check("model_dis", {5'b0, out_dis}, {5'b0, exp_v[1]});
  endtask

  task automatic do_reset(input int ncyc);
    reset_n  = 1'b0;
    key_flag = 1'b0;
    #1;
    model_reset();
    check("reset_en", {5'b0, out_en}, 10'b0);
    check("reset_dis", {5'b0, out_dis}, 10'b0);
    repeat (ncyc) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic       lvl;
    logic       s;
    int         gap;
    logic [9:0] exp;

    key_flag  = 1'b0;
    key_state = 1'b1;
    reset_n   = 1'b1;
    model_reset();
    #2;
    do_reset(3);

    // Short, double, long+repeat and tie gestures; outputs checked after the strobe cycle.
    vecs[0]  = '{0,  1'b1, 1'b0, 5'b00001, 5'b00001};
    vecs[1]  = '{9,  1'b1, 1'b1, 5'b00000, 5'b10000};
    vecs[2]  = '{29, 1'b0, 1'b0, 5'b10000, 5'b00000};
    vecs[3]  = '{0,  1'b0, 1'b0, 5'b00000, 5'b00000};
    vecs[4]  = '{4,  1'b1, 1'b0, 5'b00001, 5'b00001};
    vecs[5]  = '{9,  1'b1, 1'b1, 5'b00000, 5'b10000};
    vecs[6]  = '{14, 1'b1, 1'b0, 5'b00001, 5'b00001};
    vecs[7]  = '{4,  1'b1, 1'b1, 5'b01000, 5'b10000};
    vecs[8]  = '{40, 1'b0, 1'b0, 5'b00000, 5'b00000};
    vecs[9]  = '{0,  1'b1, 1'b0, 5'b00001, 5'b00001};
    vecs[10] = '{99, 1'b0, 1'b0, 5'b00101, 5'b00101};
    vecs[11] = '{19, 1'b0, 1'b0, 5'b00011, 5'b00011};
    vecs[12] = '{19, 1'b0, 1'b0, 5'b00011, 5'b00011};
    vecs[13] = '{4,  1'b1, 1'b1, 5'b00000, 5'b00000};
    vecs[14] = '{5,  1'b1, 1'b0, 5'b00001, 5'b00001};
    vecs[15] = '{99, 1'b1, 1'b1, 5'b00000, 5'b10000};
    vecs[16] = '{29, 1'b0, 1'b0, 5'b10000, 5'b00000};
    vecs[17] = '{3,  1'b1, 1'b0, 5'b00001, 5'b00001};
    vecs[18] = '{9,  1'b1, 1'b1, 5'b00000, 5'b10000};
    vecs[19] = '{29, 1'b1, 1'b0, 5'b00001, 5'b00001};
    vecs[20] = '{2,  1'b1, 1'b1, 5'b01000, 5'b10000};

    for (int i = 0; i < 21; i++) begin
      repeat (vecs[i].idle) step(1'b0, 1'b0);
      step(vecs[i].kf, vecs[i].ks);
      exp_q.push_back({vecs[i].exp_en, vecs[i].exp_dis});
      exp = exp_q.pop_front();
      check($sformatf("vec%0d", i), {out_en, out_dis}, exp);
    end

    // Reset while in LONG_HELD, then a stray release and a fresh short click.
    step(1'b1, 1'b0);
    repeat (105) step(1'b0, 1'b0);
    check("long_held_pressed", {out_en, out_dis}, {5'b00001, 5'b00001});
    do_reset(3);
    step(1'b1, 1'b1);
    check("stray_release", {out_en, out_dis}, 10'b0);
    repeat (2) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (9) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    check("post_reset_dis_short", {5'b0, out_dis}, {5'b0, 5'b10000});
    repeat (29) step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("post_reset_en_short", {5'b0, out_en}, {5'b0, 5'b10000});
    repeat (5) step(1'b0, 1'b0);

    // Random gestures with gaps clustered around the window, long and repeat boundaries.
    lvl = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0:       gap = $urandom_range(0, 4);
        1:       gap = $urandom_range(8, 40);
        2:       gap = $urandom_range(95, 105);
        3:       gap = $urandom_range(110, 170);
        default: gap = $urandom_range(15, 25);
      endcase
      repeat (gap) step(1'b0, 1'b0);
      if ($urandom_range(0, 9) == 0) s = 1'($urandom_range(0, 1));
      else s = ~lvl;
      step(1'b1, s);
      lvl = s;
      if ($urandom_range(0, 49) == 0) begin
        do_reset($urandom_range(1, 4));
        lvl = 1'b1;
      end
    end
    repeat (200) step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
